risc_toy_fetch_queue: RTL and testbench

//  Parametrised instruction-fetch front end for the RISC_TOY pipeline. It drives the IREQ/IADDR/INSTR

---
 rtl/risc_toy_pkg.sv | 14 +
 rtl/risc_toy_fifo.sv | 57 +++++
 rtl/risc_toy_fetch_queue.sv | 98 +++++++++
 tb/tb_risc_toy_fetch_queue.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_toy_pkg.sv
// Shared constants for the RISC_TOY fetch front end: FSM encoding and default widths.
package risc_toy_pkg;

    localparam int IW_DEFAULT = 32;
    localparam int AW_DEFAULT = 30;
    localparam logic [29:0] RESET_PC_DEFAULT = 30'h0;

    typedef logic [1:0] fetch_state_t;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

endpackage

// File: rtl/risc_toy_fifo.sv
// Generic show-ahead FIFO with flush; pointers wrap at DEPTH so any DEPTH >= 2 works.
module risc_toy_fifo #(
    parameter int WIDTH = 62,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           push_data,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_data = mem[rd_ptr_reg];
    assign count     = count_reg;

endmodule

// File: rtl/risc_toy_fetch_queue.sv
// Instruction-fetch front end: issues sequential fetches, buffers {pc, instr} pairs,
// and serves decode over valid/ready with redirect flush and halt.
module risc_toy_fetch_queue
    import risc_toy_pkg::*;
#(
    parameter int            IW       = IW_DEFAULT,
    parameter int            AW       = AW_DEFAULT,
    parameter int            DEPTH    = 4,
    parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEFAULT)
) (
    input  logic                       CLK,
    input  logic                       RSTN,
    output logic                       IREQ,
    output logic [AW-1:0]              IADDR,
    input  logic [IW-1:0]              INSTR,
    input  logic                       REDIR_VALID,
    input  logic [AW-1:0]              REDIR_ADDR,
    input  logic                       HALT,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [IW-1:0]              OUT_INSTR,
    output logic [AW-1:0]              OUT_PC,
    output logic [$clog2(DEPTH+1)-1:0] COUNT
);

    localparam int CW = $clog2(DEPTH+1);

    fetch_state_t     state_reg;
    fetch_state_t     state_next;
    logic [AW-1:0]    fetch_pc_reg;
    logic [AW-1:0]    inflight_pc_reg;
    logic             inflight_reg;
    logic             issue;
    logic             push;
    logic             pop;
    logic [CW-1:0]    count_w;
    logic [CW:0]      occupancy;
    logic [AW+IW-1:0] head_w;

    // Credit counts the outstanding fetch but not a same-cycle pop, so a push always has room.
    assign occupancy = {1'b0, count_w} + {{CW{1'b0}}, inflight_reg};
    assign issue     = (state_reg == S_RUN) && !HALT && !REDIR_VALID
                       && (occupancy < (CW+1)'(DEPTH));
    assign push      = inflight_reg && !REDIR_VALID;
    assign OUT_VALID = (count_w != '0) && !REDIR_VALID;
    assign pop       = OUT_VALID && OUT_READY;

    assign IREQ      = issue;
    assign IADDR     = fetch_pc_reg;
    assign OUT_PC    = OUT_VALID ? head_w[AW+IW-1:IW] : '0;
    assign OUT_INSTR = OUT_VALID ? head_w[IW-1:0] : '0;
    assign COUNT     = count_w;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  state_next = S_RUN;
            S_RUN:   if (HALT)  state_next = S_HALT;
            S_HALT:  if (!HALT) state_next = S_RUN;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_reg       <= S_IDLE;
            fetch_pc_reg    <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
        end else begin
            state_reg    <= state_next;
            inflight_reg <= issue;
            if (REDIR_VALID) begin
                fetch_pc_reg <= REDIR_ADDR;
            end else if (issue) begin
                fetch_pc_reg <= fetch_pc_reg + AW'(1);
            end
            if (issue) begin
                inflight_pc_reg <= fetch_pc_reg;
            end
        end
    end

    risc_toy_fifo #(
        .WIDTH (AW + IW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RSTN),
        .push      (push),
        .pop       (pop),
        .flush     (REDIR_VALID),
        .push_data ({inflight_pc_reg, INSTR}),
        .head_data (head_w),
        .count     (count_w)
    );

endmodule

// File: tb/tb_risc_toy_fetch_queue.sv
// Self-checking bench for risc_toy_fetch_queue: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_risc_toy_fetch_queue;

    localparam int IW = 32;
    localparam int AW = 30;
    localparam int DEPTH = 4;
    localparam int CW = 3;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic          RSTN;
    logic          ireq;
    logic [AW-1:0] iaddr;
    logic [IW-1:0] instr;
    logic          redir_valid;
    logic [AW-1:0] redir_addr;
    logic          halt;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic [CW-1:0] count;

    logic          w_ireq;
    logic [AW-1:0] w_iaddr;
    logic [IW-1:0] w_instr;
    logic          w_out_valid;
    logic [IW-1:0] w_out_instr;
    logic [AW-1:0] w_out_pc;
    logic [CW-1:0] w_count;

    risc_toy_fetch_queue #(.IW(IW), .AW(AW), .DEPTH(DEPTH), .RESET_PC(30'h0)) dut (
        .CLK(CLK), .RSTN(RSTN), .IREQ(ireq), .IADDR(iaddr), .INSTR(instr),
        .REDIR_VALID(redir_valid), .REDIR_ADDR(redir_addr), .HALT(halt),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_INSTR(out_instr),
        .OUT_PC(out_pc), .COUNT(count)
    );

    risc_toy_fetch_queue #(.IW(IW), .AW(AW), .DEPTH(DEPTH), .RESET_PC(30'h3FFFFFFF)) dut_wrap (
        .CLK(CLK), .RSTN(RSTN), .IREQ(w_ireq), .IADDR(w_iaddr), .INSTR(w_instr),
        .REDIR_VALID(1'b0), .REDIR_ADDR(30'h0), .HALT(1'b0),
        .OUT_VALID(w_out_valid), .OUT_READY(1'b1), .OUT_INSTR(w_out_instr),
        .OUT_PC(w_out_pc), .COUNT(w_count)
    );

    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] ins;
    } entry_t;

    // Reference model: mode 0 = idle, 1 = running, 2 = halted
    int            m_mode;
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_ipc;
    bit            m_inflight;
    entry_t        m_q[$];

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    logic [AW-1:0] prev_iaddr;
    logic [AW-1:0] w_prev_iaddr;
    bit            w_rec;
    logic [AW-1:0] w_issued[$];
    logic [AW-1:0] w_outs[$];
    logic [AW-1:0] popped[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode     = 0;
        m_pc       = '0;
        m_ipc      = '0;
        m_inflight = 1'b0;
        m_q.delete();
    endtask

    // Drive inputs, compare at the falling edge, then advance the model to the next cycle.
    task automatic sample(input bit rv, input logic [AW-1:0] ra, input bit h, input bit rdy);
        int            cnt;
        bit            e_ireq;
        bit            e_valid;
        logic [AW-1:0] e_pc;
        logic [IW-1:0] e_ins;
        entry_t        e;
        redir_valid = rv;
        redir_addr  = ra;
        halt        = h;
        out_ready   = rdy;
        @(negedge CLK);
        cnt     = m_q.size();
        e_ireq  = (m_mode == 1) && !h && !rv && (cnt + int'(m_inflight) < DEPTH);
        e_valid = (cnt != 0) && !rv;
        e_pc    = e_valid ? m_q[0].pc  : '0;
        e_ins   = e_valid ? m_q[0].ins : '0;
        check("ireq",      ireq,      e_ireq);
        check("iaddr",     iaddr,     m_pc);
        check("out_valid", out_valid, e_valid);
        check("out_pc",    out_pc,    e_pc);
        check("out_instr", out_instr, e_ins);
        check("count",     count,     cnt);
        if (out_valid && rdy) begin
            popped.push_back(out_pc);
            $display("pop pc=%h instr=%h count=%0d", out_pc, out_instr, count);
        end
        if (w_rec) begin
            if (w_ireq)      w_issued.push_back(w_iaddr);
            if (w_out_valid) w_outs.push_back(w_out_pc);
        end
        if (rv) begin
            m_q.delete();
            m_pc       = ra;
            m_inflight = 1'b0;
        end else begin
            if (e_valid && rdy) void'(m_q.pop_front());
            if (m_inflight) begin
                e.pc  = m_ipc;
                e.ins = instr;
                m_q.push_back(e);
            end
            if (e_ireq) begin
                m_ipc = m_pc;
                m_pc  = m_pc + 30'd1;
            end
            m_inflight = e_ireq;
        end
        case (m_mode)
            0:       m_mode = 1;
            1:       if (h)  m_mode = 2;
            default: if (!h) m_mode = 1;
        endcase
        prev_iaddr   = iaddr;
        w_prev_iaddr = w_iaddr;
    endtask

    task automatic advance();
        @(posedge CLK);
        #1;
        instr   = {2'b00, prev_iaddr};
        w_instr = {2'b00, w_prev_iaddr};
    endtask

    task automatic step(input bit rv, input logic [AW-1:0] ra, input bit h, input bit rdy);
        sample(rv, ra, h, rdy);
        advance();
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        model_reset();
    endtask

    initial begin
        bit            hit;
        bit            ok;
        bit            rv;
        bit            h;
        logic [AW-1:0] ra;

        RSTN = 1'b0; instr = '0; w_instr = '0;
        redir_valid = 1'b0; redir_addr = '0; halt = 1'b0; out_ready = 1'b0;
        prev_iaddr = '0; w_prev_iaddr = '0; w_rec = 1'b0;
        #23;
        check("rst_ireq",      ireq,      1'b0);
        check("rst_iaddr",     iaddr,     30'h0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_pc",    out_pc,    30'h0);
        check("rst_out_instr", out_instr, 32'h0);
        check("rst_count",     count,     3'd0);
        check("rst_wrap_iaddr", w_iaddr,  30'h3FFFFFFF);
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        model_reset();
        w_rec = 1'b1;

        // Startup latency and streaming with decode always ready
        popped.delete();
        for (int c = 0; c < 26; c++) begin
            sample(1'b0, '0, 1'b0, 1'b1);
            if (c == 0) check("t1_c0_ireq", ireq, 1'b0);
            if (c == 1) begin
                check("t1_c1_ireq",  ireq,  1'b1);
                check("t1_c1_iaddr", iaddr, 30'h0);
            end
            if (c == 3) begin
                check("t1_c3_valid", out_valid, 1'b1);
                check("t1_c3_pc",    out_pc,    30'h0);
                check("t1_c3_instr", out_instr, 32'h0);
            end
            check("t2_count_le1", count <= 3'd1, 1'b1);
            advance();
        end
        check("t2_pop_count", popped.size() >= 21, 1'b1);
        ok = 1'b1;
        foreach (popped[i]) if (popped[i] !== AW'(i)) ok = 1'b0;
        check("t2_gapless", ok, 1'b1);

        w_rec = 1'b0;
        check("t6_issue_n", w_issued.size() >= 3, 1'b1);
        check("t6_out_n",   w_outs.size()   >= 3, 1'b1);
        if (w_issued.size() >= 3 && w_outs.size() >= 3) begin
            check("t6_iaddr0", w_issued[0], 30'h3FFFFFFF);
            check("t6_iaddr1", w_issued[1], 30'h0);
            check("t6_iaddr2", w_issued[2], 30'h1);
            check("t6_outpc0", w_outs[0],   30'h3FFFFFFF);
            check("t6_outpc1", w_outs[1],   30'h0);
            check("t6_outpc2", w_outs[2],   30'h1);
        end

        // Asynchronous reset in the middle of streaming
        #1;
        RSTN = 1'b0;
        #2;
        check("t1_mid_ireq",  ireq,      1'b0);
        check("t1_mid_valid", out_valid, 1'b0);
        check("t1_mid_count", count,     3'd0);
        @(posedge CLK);
        #1;
        RSTN = 1'b1;
        model_reset();

        // Back-pressure fills the queue then drains in order
        for (int c = 0; c < 8; c++) step(1'b0, '0, 1'b0, 1'b0);
        sample(1'b0, '0, 1'b0, 1'b0);
        check("t3_count", count, 3'd4);
        check("t3_ireq",  ireq,  1'b0);
        check("t3_iaddr", iaddr, 30'h4);
        advance();
        popped.delete();
        for (int c = 0; c < 8; c++) step(1'b0, '0, 1'b0, 1'b1);
        check("t3_pop_n", popped.size() >= 5, 1'b1);
        if (popped.size() >= 5) begin
            ok = 1'b1;
            for (int i = 0; i < 5; i++) if (popped[i] !== AW'(i)) ok = 1'b0;
            check("t3_order", ok, 1'b1);
        end

        // Redirect with two queued entries and one fetch in flight
        do_reset();
        hit = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (m_q.size() == 2 && m_inflight) begin
                hit = 1'b1;
                break;
            end
            step(1'b0, '0, 1'b0, 1'b0);
        end
        check("t4_setup", hit, 1'b1);
        popped.delete();
        step(1'b1, 30'h100, 1'b0, 1'b0);
        sample(1'b0, '0, 1'b0, 1'b1);
        check("t4_count", count, 3'd0);
        check("t4_iaddr", iaddr, 30'h100);
        check("t4_ireq",  ireq,  1'b1);
        advance();
        for (int c = 0; c < 6; c++) step(1'b0, '0, 1'b0, 1'b1);
        check("t4_pop_n", popped.size() >= 2, 1'b1);
        if (popped.size() >= 2) begin
            check("t4_pc0", popped[0], 30'h100);
            check("t4_pc1", popped[1], 30'h101);
        end

        // Halt stops issue, lets the queue drain, and resumes at the next address
        do_reset();
        hit = 1'b0;
        for (int c = 0; c < 30 && !hit; c++) begin
            sample(1'b0, '0, 1'b0, 1'b1);
            hit = ireq && (iaddr == 30'h7);
            advance();
        end
        check("t5_reach7", hit, 1'b1);
        for (int c = 0; c < 8; c++) begin
            sample(1'b0, '0, 1'b1, 1'b1);
            check("t5_noreq", ireq, 1'b0);
            advance();
        end
        sample(1'b0, '0, 1'b1, 1'b1);
        check("t5_drained", count, 3'd0);
        advance();
        hit = 1'b0;
        for (int c = 0; c < 5 && !hit; c++) begin
            sample(1'b0, '0, 1'b0, 1'b1);
            if (ireq) begin
                hit = 1'b1;
                check("t5_resume_iaddr", iaddr, 30'h8);
            end
            advance();
        end
        check("t5_resumed", hit, 1'b1);

        // Randomized mix of redirects, halts and decode stalls
        do_reset();
        h = 1'b0;
        for (int c = 0; c < 400; c++) begin
            rv = ($urandom_range(0, 9) == 0);
            ra = ($urandom_range(0, 3) == 0) ? 30'h3FFFFFFE + AW'($urandom_range(0, 3))
                                             : AW'($urandom);
            if ($urandom_range(0, 9) == 0) h = ~h;
            step(rv, ra, h, $urandom_range(0, 2) != 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
